// File: rtl/occupancy_gate_ctrl_if.sv
// Signal bundle between the door sensors / request button and the
// occupancy gate controller. The master drives the sensor and request
// inputs; the slave (the controller) drives the door and status outputs.
// With TAILGATE_ALARM_EN defined the bundle also carries the ALARM output.
interface occupancy_gate_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             T;
    logic             ENT;
    logic             IN;
    logic             OUT;
    logic             OPEN;
    logic             CLOSE;
    logic [CNT_W-1:0] COUNT;
    logic             FULL;
    logic             EMPTY;
    logic             DENY;
`ifdef TAILGATE_ALARM_EN
    logic             ALARM;

    modport master (
        output T, ENT, IN, OUT,
        input  OPEN, CLOSE, COUNT, FULL, EMPTY, DENY, ALARM
    );

    modport slave (
        input  T, ENT, IN, OUT,
        output OPEN, CLOSE, COUNT, FULL, EMPTY, DENY, ALARM
    );
`else
    modport master (
        output T, ENT, IN, OUT,
        input  OPEN, CLOSE, COUNT, FULL, EMPTY, DENY
    );

    modport slave (
        input  T, ENT, IN, OUT,
        output OPEN, CLOSE, COUNT, FULL, EMPTY, DENY
    );
`endif
endinterface

// File: rtl/occupancy_gate_ctrl.sv
// Room occupancy controller with timed door grant.
// Counts people in a room of capacity CAP, opens the door for at most
// OPEN_CYC cycles per granted request and refuses entry when full or
// outside visiting hours. Exits are always counted.
// Optional feature: define TAILGATE_ALARM_EN to add a sticky ALARM that
// flags any inward pass without a valid grant and blocks further entries.
module occupancy_gate_ctrl #(
    parameter int CAP      = 15,
    parameter int CNT_W    = 4,
    parameter int OPEN_CYC = 3
) (
    input  logic                    clk,
    input  logic                    CLR,
    occupancy_gate_ctrl_if.slave    bus
);

    localparam int               TMR_W     = $clog2(OPEN_CYC + 1);
    localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAP);
    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYC);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             open_q;
    logic             deny_q;
    logic             accepted_in;
    logic             accepted_out;
    logic             entry_ok;

`ifdef TAILGATE_ALARM_EN
    logic             alarm_q;
    logic             stray_in;

    // An inward pass is a tailgate unless it lands in an active grant during visiting hours
    always_comb begin
        stray_in = bus.IN && ((state == IDLE) || !bus.T);
    end

    // Sticky tailgate alarm, only CLR clears it
    always_ff @(posedge clk) begin
        if (CLR) begin
            alarm_q <= 1'b0;
        end else if (stray_in) begin
            alarm_q <= 1'b1;
        end
    end

    assign entry_ok  = bus.T && (count_q < CAP_V) && !alarm_q;
    assign bus.ALARM = alarm_q;
`else
    assign entry_ok  = bus.T && (count_q < CAP_V);
`endif

    // Occupancy bookkeeping: an IN only counts inside an active grant, an OUT only when someone is inside
    always_comb begin
        accepted_in  = (state == GRANT) && bus.T && bus.IN;
        accepted_out = bus.OUT && (count_q != '0);
        count_next   = count_q;
        if (accepted_in && !accepted_out) begin
            count_next = count_q + CNT_W'(1);
        end else if (!accepted_in && accepted_out) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    // Door FSM with registered OPEN/DENY outputs and the occupancy register
    always_ff @(posedge clk) begin
        if (CLR) begin
            state   <= IDLE;
            timer   <= '0;
            count_q <= '0;
            open_q  <= 1'b0;
            deny_q  <= 1'b0;
        end else begin
            deny_q  <= 1'b0;
            count_q <= count_next;
            case (state)
                IDLE: begin
                    if (bus.ENT) begin
                        if (entry_ok) begin
                            state  <= GRANT;
                            open_q <= 1'b1;
                            timer  <= OPEN_LOAD;
                        end else begin
                            deny_q <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    if (!bus.T) begin
                        state  <= IDLE;
                        open_q <= 1'b0;
                        timer  <= '0;
                    end else if (bus.IN) begin
                        state  <= IDLE;
                        open_q <= 1'b0;
                        timer  <= '0;
                    end else if (timer == TMR_ONE) begin
                        state  <= IDLE;
                        open_q <= 1'b0;
                        timer  <= '0;
                    end else begin
                        timer  <= timer - TMR_ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    open_q <= 1'b0;
                    timer  <= '0;
                end
            endcase
        end
    end

    assign bus.OPEN  = open_q;
    assign bus.CLOSE = ~open_q;
    assign bus.COUNT = count_q;
    assign bus.FULL  = (count_q == CAP_V);
    assign bus.EMPTY = (count_q == '0);
    assign bus.DENY  = deny_q;

endmodule

// File: tb/tb_occupancy_gate_ctrl.sv
// Directed self-checking bench for occupancy_gate_ctrl with the default
// parameters (CAP=15, CNT_W=4, OPEN_CYC=3). Expected values are hand
// derived from the controller's behaviour.
module tb_occupancy_gate_ctrl;

    localparam int CAP      = 15;
    localparam int CNT_W    = 4;
    localparam int OPEN_CYC = 3;

    logic clk;
    logic CLR;
    int   checkCount;
    int   errorCount;

    occupancy_gate_ctrl_if #(.CNT_W(CNT_W)) bus ();

    occupancy_gate_ctrl #(
        .CAP      (CAP),
        .CNT_W    (CNT_W),
        .OPEN_CYC (OPEN_CYC)
    ) dut (
        .clk (clk),
        .CLR (CLR),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-derived expectation
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then wait until just after the next rising edge
    task automatic applyStimulus(input logic clr, input logic t, input logic ent,
                                 input logic inp, input logic outp);
        CLR     = clr;
        bus.T   = t;
        bus.ENT = ent;
        bus.IN  = inp;
        bus.OUT = outp;
        @(posedge clk);
        #1;
    endtask

    // Scripted test sequence
    initial begin
        checkCount = 0;
        errorCount = 0;
        CLR     = 1'b1;
        bus.T   = 1'b0;
        bus.ENT = 1'b0;
        bus.IN  = 1'b0;
        bus.OUT = 1'b0;
        @(negedge clk);

        // Reset state
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_count", int'(bus.COUNT), 0);
        checkOutput("rst_open",  int'(bus.OPEN),  0);
        checkOutput("rst_close", int'(bus.CLOSE), 1);
        checkOutput("rst_empty", int'(bus.EMPTY), 1);
        checkOutput("rst_full",  int'(bus.FULL),  0);
        checkOutput("rst_deny",  int'(bus.DENY),  0);

        // Fill the room one granted entry at a time
        for (int i = 1; i <= CAP; i++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkOutput("fill_open", int'(bus.OPEN), 1);
            applyStimulus(0, 1, 0, 1, 0);
            checkOutput("fill_count", int'(bus.COUNT), i);
            checkOutput("fill_close", int'(bus.OPEN), 0);
        end
        checkOutput("full_flag", int'(bus.FULL), 1);
        checkOutput("full_empty", int'(bus.EMPTY), 0);

        // Request while full is refused for one cycle
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("full_deny", int'(bus.DENY), 1);
        checkOutput("full_open", int'(bus.OPEN), 0);
        checkOutput("full_count", int'(bus.COUNT), 15);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("deny_pulse_end", int'(bus.DENY), 0);

        // Held request while full re-pulses DENY every cycle
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("held_deny1", int'(bus.DENY), 1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("held_deny2", int'(bus.DENY), 1);

        // Request plus exit while full: decision uses the pre-exit count
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("entout_deny",  int'(bus.DENY),  1);
        checkOutput("entout_open",  int'(bus.OPEN),  0);
        checkOutput("entout_count", int'(bus.COUNT), 14);
        checkOutput("entout_full",  int'(bus.FULL),  0);

        // Freed slot can now be granted and filled again
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("refill_open", int'(bus.OPEN), 1);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("refill_count", int'(bus.COUNT), 15);
        checkOutput("refill_open0", int'(bus.OPEN), 0);
        checkOutput("refill_full", int'(bus.FULL), 1);

        // Timeout: door open exactly OPEN_CYC cycles, ENT during grant ignored
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("to_pre_count", int'(bus.COUNT), 14);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("to_open1", int'(bus.OPEN), 1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("to_open2", int'(bus.OPEN), 1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("to_open3", int'(bus.OPEN), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("to_closed", int'(bus.OPEN), 0);
        checkOutput("to_close1", int'(bus.CLOSE), 1);
        checkOutput("to_count", int'(bus.COUNT), 14);

        // Visiting hours end during a grant: abort without increment
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("abort_open", int'(bus.OPEN), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("abort_closed", int'(bus.OPEN), 0);
        checkOutput("abort_count", int'(bus.COUNT), 14);

        // Simultaneous IN and OUT inside a grant: count unchanged, door closes
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("inout_open", int'(bus.OPEN), 1);
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("inout_count", int'(bus.COUNT), 14);
        checkOutput("inout_open0", int'(bus.OPEN), 0);

        // Drain the room, then one extra exit must not underflow
        for (int i = 13; i >= 0; i--) begin
            applyStimulus(0, 1, 0, 0, 1);
            checkOutput("drain_count", int'(bus.COUNT), i);
        end
        checkOutput("drain_empty", int'(bus.EMPTY), 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("underflow_count", int'(bus.COUNT), 0);
        checkOutput("underflow_empty", int'(bus.EMPTY), 1);

        // Outside visiting hours every request is refused
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("hours_deny", int'(bus.DENY), 1);
        checkOutput("hours_open", int'(bus.OPEN), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("hours_deny_end", int'(bus.DENY), 0);

        // Reset in the middle of a grant closes the door and clears the count
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("clr_pre_count", int'(bus.COUNT), 1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("clr_pre_open", int'(bus.OPEN), 1);
        applyStimulus(1, 1, 0, 1, 0);
        checkOutput("clr_open", int'(bus.OPEN), 0);
        checkOutput("clr_count", int'(bus.COUNT), 0);
        applyStimulus(0, 1, 0, 0, 0);

`ifdef TAILGATE_ALARM_EN
        // Stray IN while idle raises the alarm and blocks entries until reset
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("alarm_set", int'(bus.ALARM), 1);
        checkOutput("alarm_count", int'(bus.COUNT), 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("alarm_deny", int'(bus.DENY), 1);
        checkOutput("alarm_open", int'(bus.OPEN), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("alarm_clr", int'(bus.ALARM), 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("alarm_regrant", int'(bus.OPEN), 1);
`else
        // Stray IN while idle is ignored and does not block a later grant
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("stray_count", int'(bus.COUNT), 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("stray_grant", int'(bus.OPEN), 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("stray_abort_count", int'(bus.COUNT), 0);
        checkOutput("stray_abort_open", int'(bus.OPEN), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/occupancy_gate_ctrl.md
Name: occupancy_gate_ctrl

Overview:
Parametrised next-generation room occupancy controller.
- Counts people in a room of configurable capacity.
- Grants entry on request by opening the door for a bounded window, and closes on entry or timeout.
- Refuses entry when the room is full or outside visiting hours (T=0). Exits are always allowed.
- Sits between the door sensors/request button and the door actuator.

Parameters:
CAP, 15, maximum occupancy (1..2**CNT_W-1)
CNT_W, 4, width of the occupancy counter
OPEN_CYC, 3, cycles the door stays open waiting for IN before timing out (>=1)

Ports:
clk  input  1  system clock, rising edge
CLR  input  1  synchronous active-high reset
T  input  1  visiting-hours enable; 1 = entries allowed
ENT  input  1  entry request (level sampled each cycle)
IN  input  1  entry sensor pulse; a person passed inward
OUT  input  1  exit sensor pulse; a person passed outward
OPEN  output  1  door open command
CLOSE  output  1  door closed indication, always ~OPEN
COUNT  output  CNT_W  current occupancy
FULL  output  1  COUNT == CAP
EMPTY  output  1  COUNT == 0
DENY  output  1  one-cycle pulse: entry request refused

Behaviour:
- Single clock domain. CLR is synchronous and active-high, with priority over all other inputs.
- Reset values: COUNT=0, OPEN=0, CLOSE=1, FULL=0, EMPTY=1, DENY=0, state=IDLE, timer=0.
- FSM states:
  - IDLE: door closed.
  - GRANT: door open, timer running.
- IDLE transitions, for ENT=1 sampled at edge k:
  - If T=1 and COUNT<CAP: go to GRANT. OPEN=1 from edge k onward. Timer loads OPEN_CYC.
  - Else: stay in IDLE. DENY=1 for exactly one cycle after edge k.
  - ENT held high while refused re-pulses DENY every cycle.
- GRANT transitions, evaluated each edge in this priority order:
  - T=0: abort to IDLE, no increment. An IN in that same cycle is ignored.
  - IN=1: COUNT+1, go to IDLE. OPEN drops after that edge.
  - Timer reaches 1 with no IN: go to IDLE, no increment. OPEN is high for exactly OPEN_CYC cycles.
  - Otherwise: decrement timer.
  - ENT during GRANT is ignored. It does not restart the timer.
- OUT=1 is accepted in any state:
  - Decrements COUNT if COUNT>0.
  - OUT at COUNT=0 is ignored, with no underflow.
- Simultaneous accepted IN and OUT in the same cycle: COUNT unchanged, FSM returns to IDLE.
- IN in IDLE (no grant) never changes COUNT.
- COUNT saturation:
  - COUNT never exceeds CAP, because grant requires COUNT<CAP.
  - OUT in the grant cycle frees a slot, but the grant already decided stands.
- FULL and EMPTY are combinational from the COUNT register, with no extra latency.
- CLR mid-GRANT: door closes on the next edge (OPEN=0) and COUNT=0.
- All outputs are registered except FULL, EMPTY and CLOSE (decode of registered state).

Optional Feature:
Macro TAILGATE_ALARM_EN.
- Defined:
  - Adds output port ALARM (1 bit).
  - ALARM is set on the edge after any IN=1 sampled while in IDLE, or in GRANT when T=0.
  - ALARM is sticky and cleared only by CLR.
  - While ALARM=1, every ENT is refused with DENY, regardless of T and COUNT. Exits still function.
- Not defined: ALARM port absent; stray IN is silently ignored.

Test Plan:
1. CLR=1 for 1 cycle, then CLR=0 -> COUNT=0, OPEN=0, CLOSE=1, EMPTY=1, FULL=0, DENY=0.
2. T=1, repeat 15x (ENT 1 cycle, then IN 1 cycle) -> COUNT steps 1..15, FULL=1 at 15. A 16th ENT -> DENY=1 for one cycle, OPEN stays 0, COUNT=15.
3. At COUNT=15: OUT 1 cycle -> COUNT=14, FULL=0. Then ENT -> OPEN=1. IN -> COUNT=15, OPEN=0 next cycle.
4. ENT with no IN, OPEN_CYC=3 -> OPEN high exactly 3 cycles, then CLOSE=1, COUNT unchanged.
5. 15x OUT pulses from COUNT=15 -> COUNT=0, EMPTY=1. An extra OUT -> COUNT stays 0. Then T=0 and ENT -> DENY=1, no OPEN.
6. In GRANT, assert IN and OUT together -> COUNT unchanged, OPEN=0. With TAILGATE_ALARM_EN defined, IN in IDLE -> ALARM=1; a later ENT -> DENY; CLR -> ALARM=0.
